sprite_line_fetch: RTL and testbench
====================================

# sprite_line_fetch

Scanline prefetch controller for the player sprite ROM (1<<ADDRESS words of COLOR_BITS, asynchronous read). During each horizontal blanking interval it sequences the ROM through the sprite row needed by the next visible line and captures it in an internal SPR_W-entry line buffer. During active video it streams buffered pixels to the pixel mux with a registered transparency flag. It sits between the VGA timing generator (hcount/vcount) and the sprite ROM.

## Interface
- ADDRESS, 10, sprite ROM address width; SPR_W*SPR_H == 1<<ADDRESS
- COLOR_BITS, 24, pixel width (24 or 12)
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in lines
- COORD_W, 10, hcount/vcount/position width
- H_ACTIVE, 640; H_TOTAL, 800; V_ACTIVE, 480; V_TOTAL, 525: raster geometry
- TRANSPARENT, 24'hFF00FF (truncated to COLOR_BITS), color key

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount  in  COORD_W  current pixel column, increments by 1 per clk, wraps at H_TOTAL
- vcount  in  COORD_W  current line, wraps at V_TOTAL
- enable  in  1  sprite display enable
- sprite_x  in  COORD_W  requested sprite left column
- sprite_y  in  COORD_W  requested sprite top line
- rom_addr  out  ADDRESS  sprite ROM address
- rom_data  in  COLOR_BITS  sprite ROM data, valid same cycle as rom_addr
- pix_color  out  COLOR_BITS  sprite pixel color
- pix_valid  out  1  sprite pixel opaque and present
- busy  out  1  row fetch in progress

## Operation
- Reset: state IDLE, pos_x=pos_y=0, line_hit=0, col=0, rom_addr=0, pix_color=0, pix_valid=0, busy=0; buffer contents don't-care.
- Position latch: on cycle with hcount==0 && vcount==V_ACTIVE (vblank start), pos_x<=sprite_x, pos_y<=sprite_y. Position changes at any other time have no visible effect until then.
- Trigger: cycle with hcount==H_ACTIVE. next_line = (vcount==V_TOTAL-1) ? 0 : vcount+1. Hit iff enable && next_line>=pos_y && next_line<pos_y+SPR_H (sum in COORD_W+1 bits).
- Trigger in IDLE/READY, hit: line_hit<=0, row<=next_line-pos_y, col<=0, go FETCH.
- Trigger, no hit: line_hit<=0, go IDLE.
- FETCH: rom_addr=row*SPR_W+col (combinational from registers); buf[col]<=rom_data; col increments; after col==SPR_W-1 store, line_hit<=1, go READY. busy=1 only in FETCH.
- Trigger seen while in FETCH: ignored (cannot occur when SPR_W<=H_TOTAL-H_ACTIVE).
- rom_addr=0 outside FETCH.
- Display (every cycle): in_spr = hcount<H_ACTIVE && vcount<V_ACTIVE && line_hit && hcount>=pos_x && hcount<pos_x+SPR_W (COORD_W+1-bit sum). If in_spr: pix_color<=buf[hcount-pos_x], pix_valid<=(buf[hcount-pos_x]!=TRANSPARENT); else pix_color<=0, pix_valid<=0.
- Clipping: columns at or beyond H_ACTIVE and lines at or beyond V_ACTIVE never display; no wrap-around to left/top edges.
- enable sampled only at trigger; deassertion mid-line leaves the current line drawn.

## Timing
- Fetch: starts cycle after trigger, SPR_W cycles, one ROM word per cycle; line_hit rises on cycle trigger+SPR_W+1, completing within hblank.
- Display latency: pix_color/pix_valid reflect the hcount/vcount presented one clock earlier.
- Line 0 fetch occurs at vcount==V_TOTAL-1, after the vblank latch, so each frame uses one consistent position.
- Reset asserted mid-fetch: immediate return to reset values; no further ROM addressing until next trigger after release.

## Test plan
- Reset: assert rst_n=0 mid-line -> all outputs 0, busy=0; after release no fetch until hcount==640.
- Sprite at (100,50), ROM word n=n: at vcount=49,hcount=640 -> rom_addr 0..31 over 32 cycles, busy=1; line 50 -> pix_valid=1 for hcount 100..131 (seen one cycle later), pix_color=0..31; line 82 -> pix_valid=0.
- Transparency: ROM word 5 = 24'hFF00FF at pos (100,50) -> line 50, hcount 105 gives pix_valid=0, neighbours valid.
- Position update mid-frame: sprite_y 50->200 at vcount=60 -> lines 61..81 still drawn from y=50; next frame drawn from line 200.
- Wrap: pos (0,0) -> fetch of row 0 at vcount=524; line 0 hcount 0..31 valid; line 31 last row addr 992..1023.
- Right clip / enable: pos_x=620 -> only hcount 620..639 valid; enable=0 at trigger -> next line pix_valid=0, rom_addr stays 0.

Source files
------------

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: fetches the next line's sprite row from ROM during hblank and streams it during active video.
//   clk, rst_n             pixel clock, asynchronous active-low reset
//   hcount, vcount         raster position from the VGA timing generator
//   enable                 sprite enable, sampled at the start of hblank
//   sprite_x, sprite_y     requested position, latched at the start of vblank
//   rom_addr, rom_data     sprite ROM port (asynchronous read)
//   pix_color, pix_valid   registered sprite pixel and opacity flag
//   busy                   high while a row fetch is in progress
module sprite_line_fetch #(
  parameter int          ADDRESS     = 10,
  parameter int          COLOR_BITS  = 24,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter int          COORD_W     = 10,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_TOTAL     = 800,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_TOTAL     = 525,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    hcount,
  input  logic [COORD_W-1:0]    vcount,
  input  logic                  enable,
  input  logic [COORD_W-1:0]    sprite_x,
  input  logic [COORD_W-1:0]    sprite_y,
  output logic [ADDRESS-1:0]    rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_valid,
  output logic                  busy
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [COLOR_BITS-1:0] KEY = TRANSPARENT[COLOR_BITS-1:0];
  // The whole row must fit inside hblank, and the ROM must hold exactly one sprite.
  if (SPR_W > H_TOTAL - H_ACTIVE || SPR_W * SPR_H != (1 << ADDRESS)) begin : g_bad_cfg
    $error("sprite_line_fetch: sprite geometry does not fit ROM or hblank");
  end
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
  state_t r_state, w_next;
  logic [COORD_W-1:0]    r_pos_x, r_pos_y;
  logic                  r_line_hit;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [COLOR_BITS-1:0] r_buf [SPR_W];
  logic [COLOR_BITS-1:0] r_pix_color;
  logic                  r_pix_valid;
  logic                  w_trig, w_latch, w_hit, w_last, w_in_spr;
  logic [COORD_W-1:0]    w_next_line;
  logic [RW-1:0]         w_row_off;
  logic [CW-1:0]         w_col_off;
  logic [COLOR_BITS-1:0] w_pix;
  assign w_trig      = hcount == COORD_W'(H_ACTIVE);
  assign w_latch     = hcount == '0 && vcount == COORD_W'(V_ACTIVE);
  assign w_next_line = (vcount == COORD_W'(V_TOTAL - 1)) ? '0 : vcount + COORD_W'(1);
  // Sums are widened by one bit so sprites near the coordinate limit never wrap.
  assign w_hit       = enable && w_next_line >= r_pos_y &&
                       {1'b0, w_next_line} < {1'b0, r_pos_y} + (COORD_W+1)'(SPR_H);
  assign w_row_off   = RW'(w_next_line - r_pos_y);
  assign w_last      = r_col == CW'(SPR_W - 1);
  assign w_in_spr    = hcount < COORD_W'(H_ACTIVE) && vcount < COORD_W'(V_ACTIVE) && r_line_hit &&
                       hcount >= r_pos_x && {1'b0, hcount} < {1'b0, r_pos_x} + (COORD_W+1)'(SPR_W);
  assign w_col_off   = CW'(hcount - r_pos_x);
  assign w_pix       = r_buf[w_col_off];
  assign busy        = r_state == FETCH;
  assign rom_addr    = busy ? ADDRESS'(r_row) * ADDRESS'(SPR_W) + ADDRESS'(r_col) : '0;
  assign pix_color   = r_pix_color;
  assign pix_valid   = r_pix_valid;
  // A trigger arriving mid-fetch is ignored; it cannot happen while the row fits in hblank.
  always_comb begin
    w_next = r_state;
    if (r_state == FETCH) w_next = w_last ? READY : FETCH;
    else if (w_trig) w_next = w_hit ? FETCH : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_line_hit  <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_pix_color <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_pos_x <= sprite_x;
        r_pos_y <= sprite_y;
      end
      if (r_state != FETCH && w_trig) begin
        r_line_hit <= 1'b0;
        r_row      <= w_row_off;
        r_col      <= '0;
      end
      if (r_state == FETCH) begin
        r_col <= r_col + CW'(1);
        if (w_last) r_line_hit <= 1'b1;
      end
      r_pix_color <= w_in_spr ? w_pix : '0;
      r_pix_valid <= w_in_spr && w_pix != KEY;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) r_buf[r_col] <= rom_data;
  end
endmodule

// File: tb/tb_sprite_line_fetch.sv
// tb_sprite_line_fetch: randomized and directed checks of sprite_line_fetch against a per-line raster model.
module tb_sprite_line_fetch;
  localparam logic [23:0] KEY = 24'hFF00FF;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [9:0]  hcount = 0;
  logic [9:0]  vcount = 0;
  logic        enable = 1;
  logic [9:0]  sprite_x = 0;
  logic [9:0]  sprite_y = 0;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pix_color;
  logic        pix_valid;
  logic        busy;
  logic [23:0] rom [1024];
  logic [23:0] m_buf [32];
  int          m_px = 0;
  int          m_py = 0;
  int          frow = -1;
  bit          m_hit = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  sprite_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .enable(enable),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_color(pix_color), .pix_valid(pix_valid), .busy(busy)
  );
  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;
  // Drives one raster line (active part plus enough hblank to finish a fetch) and checks every cycle.
  task automatic run_line(input int v, output int nv);
    logic [23:0] ec;
    bit          in_s, ev, eb;
    int          ea, k, nl;
    nv = 0;
    for (int h = 0; h < 680; h++) begin
      hcount = 10'(h);
      vcount = 10'(v);
      in_s = h < 640 && v < 480 && m_hit && h >= m_px && h < m_px + 32;
      ec = in_s ? m_buf[h - m_px] : 24'h0;
      ev = in_s && ec != KEY;
      if (h == 0 && v == 480) begin
        m_px = int'(sprite_x);
        m_py = int'(sprite_y);
      end
      if (h == 640) begin
        nl = (v == 524) ? 0 : v + 1;
        m_hit = 0;
        frow = (enable && nl >= m_py && nl < m_py + 32) ? nl - m_py : -1;
      end
      @(posedge clk);
      #1;
      k = h - 640;
      eb = frow >= 0 && k >= 0 && k < 32;
      ea = eb ? frow * 32 + k : 0;
      if (h == 672 && frow >= 0) begin
        for (int i = 0; i < 32; i++) m_buf[i] = rom[frow * 32 + i];
        m_hit = 1;
      end
      if (pix_valid === 1'b1) nv++;
      n_checks++;
      if (pix_valid !== ev) $display("FAIL pix_valid v=%0d h=%0d got %b want %b", v, h, pix_valid, ev);
      else n_pass++;
      n_checks++;
      if (pix_color !== ec) $display("FAIL pix_color v=%0d h=%0d got %h want %h", v, h, pix_color, ec);
      else n_pass++;
      n_checks++;
      if (busy !== eb) $display("FAIL busy v=%0d h=%0d got %b want %b", v, h, busy, eb);
      else n_pass++;
      n_checks++;
      if (rom_addr !== 10'(ea)) $display("FAIL rom_addr v=%0d h=%0d got %0d want %0d", v, h, rom_addr, ea);
      else n_pass++;
    end
  endtask
  task automatic check_nv(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s opaque pixels got %0d want %0d", name, got, want);
    else n_pass++;
  endtask
  task automatic test_reset;
    hcount = 10'd320;
    vcount = 10'd20;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rom_addr, pix_color, pix_valid, busy} !== '0)
      $display("FAIL reset_outputs got addr=%0d color=%h valid=%b busy=%b want all 0", rom_addr, pix_color, pix_valid, busy);
    else n_pass++;
    rst_n = 1;
    for (int h = 600; h < 640; h++) begin
      hcount = 10'(h);
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_no_fetch h=%0d busy got %b want 0", h, busy);
      else n_pass++;
    end
  endtask
  task automatic test_basic;
    int nv;
    for (int i = 0; i < 1024; i++) rom[i] = 24'(i);
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    enable = 1;
    run_line(480, nv);
    run_line(49, nv);
    run_line(50, nv);
    check_nv("basic_line50", nv, 32);
    run_line(81, nv);
    run_line(82, nv);
    check_nv("basic_line82", nv, 0);
  endtask
  task automatic test_transparency;
    int nv;
    rom[5] = KEY;
    run_line(49, nv);
    run_line(50, nv);
    check_nv("transparent_line50", nv, 31);
    rom[5] = 24'd5;
  endtask
  task automatic test_pos_update;
    int nv;
    run_line(59, nv);
    sprite_y = 10'd200;
    run_line(60, nv);
    run_line(61, nv);
    check_nv("pos_old_line61", nv, 32);
    run_line(80, nv);
    run_line(81, nv);
    check_nv("pos_old_line81", nv, 32);
    run_line(480, nv);
    run_line(199, nv);
    run_line(200, nv);
    check_nv("pos_new_line200", nv, 32);
    run_line(49, nv);
    run_line(50, nv);
    check_nv("pos_new_line50", nv, 0);
  endtask
  task automatic test_wrap;
    int nv;
    sprite_x = 0;
    sprite_y = 0;
    run_line(480, nv);
    run_line(524, nv);
    run_line(0, nv);
    check_nv("wrap_line0", nv, 32);
    run_line(30, nv);
    run_line(31, nv);
    check_nv("wrap_line31", nv, 32);
  endtask
  task automatic test_clip_enable;
    int nv;
    sprite_x = 10'd620;
    sprite_y = 10'd100;
    run_line(480, nv);
    run_line(99, nv);
    run_line(100, nv);
    check_nv("clip_right", nv, 20);
    enable = 0;
    run_line(100, nv);
    enable = 1;
    run_line(101, nv);
    check_nv("enable_off", nv, 0);
    sprite_x = 10'd300;
    sprite_y = 10'd470;
    run_line(480, nv);
    run_line(478, nv);
    run_line(479, nv);
    check_nv("clip_bottom_479", nv, 32);
    run_line(480, nv);
    check_nv("clip_bottom_480", nv, 0);
  endtask
  task automatic test_random;
    int nv, r;
    for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
    for (int it = 0; it < 6; it++) begin
      sprite_x = 10'($urandom_range(0, 639));
      sprite_y = 10'($urandom_range(0, 479));
      enable = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 479);
      run_line(480, nv);
      run_line(r == 0 ? 524 : r - 1, nv);
      run_line(r, nv);
    end
    enable = 1;
  endtask
  task automatic test_reset_mid;
    int nv;
    for (int i = 0; i < 1024; i++) rom[i] = 24'(i);
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    run_line(480, nv);
    vcount = 10'd49;
    for (int k = 0; k < 5; k++) begin
      hcount = 10'(640 + k);
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy !== 1'b1 || rom_addr !== 10'd4) $display("FAIL midfetch got busy=%b addr=%0d want busy=1 addr=4", busy, rom_addr);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({rom_addr, pix_color, pix_valid, busy} !== '0)
      $display("FAIL reset_mid got addr=%0d color=%h valid=%b busy=%b want all 0", rom_addr, pix_color, pix_valid, busy);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    m_px = 0;
    m_py = 0;
    m_hit = 0;
    frow = -1;
    run_line(10, nv);
    check_nv("after_reset_line10", nv, 0);
    run_line(11, nv);
    check_nv("after_reset_line11", nv, 32);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 24'(i);
    test_reset;
    test_basic;
    test_transparency;
    test_pos_update;
    test_wrap;
    test_clip_enable;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
